// File: rtl/sound_pkg.sv
// Shared constants and helpers for the I2S sound transmitter.
// Optional soft-mute ramp in sound_i2s_tx is enabled by SOUND_I2S_SOFTMUTE_EN.
package sound_pkg;

  localparam int unsigned SOUND_I2S_FRAME_BITS  = 32;
  localparam int unsigned SOUND_I2S_SAMPLE_BITS = 16;
  localparam int unsigned SOUND_I2S_ATTEN_MAX   = 16;
  localparam int unsigned SOUND_I2S_BIT_W       = $clog2(SOUND_I2S_FRAME_BITS);
  localparam int unsigned SOUND_I2S_ATTEN_W     = $clog2(SOUND_I2S_ATTEN_MAX) + 1;

  typedef logic [SOUND_I2S_SAMPLE_BITS-1:0] sample_t;
  typedef logic [SOUND_I2S_FRAME_BITS-1:0]  frame_t;
  typedef logic [SOUND_I2S_BIT_W-1:0]       bit_idx_t;
  typedef logic [SOUND_I2S_ATTEN_W-1:0]     atten_t;

  // Arithmetic right shift by the attenuation step; full attenuation is silence.
  function automatic sample_t atten_sample(input sample_t s, input atten_t a);
    if (a >= SOUND_I2S_ATTEN_W'(SOUND_I2S_ATTEN_MAX)) begin
      return '0;
    end
    return sample_t'($signed(s) >>> a);
  endfunction

endpackage

// File: rtl/sound_i2s_bclk_gen.sv
// I2S bit-clock divider: toggles bclk every BCLK_HALF clk cycles and flags
// the cycle whose closing edge drives bclk from 1 to 0.
module sound_i2s_bclk_gen #(
  parameter int unsigned BCLK_HALF = 16
) (
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic fall
);

  localparam int unsigned DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  assign wrap = (div_cnt == DIV_W'(BCLK_HALF - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // High during the cycle before bclk drops, so consumers update on the same edge.
  assign fall = wrap & bclk;

endmodule

// File: rtl/sound_i2s_tx.sv
// I2S transmitter: captures a stereo sample pair once per 32-bit frame and
// serialises it MSB first with one-bit I2S delay. Define SOUND_I2S_SOFTMUTE_EN
// for a 16-step attenuation ramp instead of hard mute.
module sound_i2s_tx
  import sound_pkg::*;
#(
  parameter int unsigned BCLK_HALF = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sample_l,
  input  logic [15:0] sample_r,
  input  logic        mute,
  output logic        frame_strobe,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_data
);

  logic     fall;
  logic     capture;
  bit_idx_t bit_cnt;
  frame_t   shreg;
  logic     held_lsb;
  sample_t  l_proc;
  sample_t  r_proc;

  sound_i2s_bclk_gen #(
    .BCLK_HALF(BCLK_HALF)
  ) u_bclk_gen (
    .clk  (clk),
    .rst  (rst),
    .bclk (i2s_bclk),
    .fall (fall)
  );

  assign capture = fall && (bit_cnt == SOUND_I2S_BIT_W'(SOUND_I2S_FRAME_BITS - 1));

`ifdef SOUND_I2S_SOFTMUTE_EN
  atten_t atten;
  atten_t atten_nxt;

  always_comb begin
    atten_nxt = atten;
    if (mute) begin
      if (atten < SOUND_I2S_ATTEN_W'(SOUND_I2S_ATTEN_MAX)) atten_nxt = atten + 1'b1;
    end else if (atten != '0) begin
      atten_nxt = atten - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      atten <= '0;
    end else if (capture) begin
      atten <= atten_nxt;
    end
  end

  // The step taken at this capture already applies to the captured pair.
  assign l_proc = atten_sample(sample_l, atten_nxt);
  assign r_proc = atten_sample(sample_r, atten_nxt);
`else
  assign l_proc = mute ? '0 : sample_l;
  assign r_proc = mute ? '0 : sample_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt      <= '0;
      shreg        <= '0;
      held_lsb     <= 1'b0;
      i2s_data     <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= capture;
      if (fall) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (capture) begin
          // Period 0 still belongs to the previous word: its right-channel LSB.
          shreg    <= {l_proc, r_proc};
          held_lsb <= r_proc[0];
          i2s_data <= held_lsb;
        end else begin
          i2s_data <= shreg[SOUND_I2S_FRAME_BITS-1];
          shreg    <= {shreg[SOUND_I2S_FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

  assign i2s_lrclk = bit_cnt[SOUND_I2S_BIT_W-1];

endmodule
